ap_function_seq: RTL and testbench
==================================

// Module: ap_function_seq
// PURPOSE
//  Parametrised, multicycle successor of the 8-bit arithmetic function unit.
//  Keeps the 8 single-cycle ALU ops and adds a shift-add multiply and barrel-free shifts.
//  Shifts are iterative, one bit per cycle. Operands enter, and results leave, via valid/ready handshakes.
//  All results and flags (n, z, cout, ovf) are registered.
//  Sits between the operand register file and the result/flag writeback stage.
// PARAMETERS
//  WIDTH  8              datapath width in bits (>=4)
//  SHW    $clog2(WIDTH)  shift-amount width, taken from b[SHW-1:0]
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      unit can accept; high only in IDLE
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (low SHW bits = shift amount for shifts)
//  cin        in   1      carry in (ADD/SUB/RSUB only)
//  aop        in   4      operation code
//  flush      in   1      sync abort: discard op in flight
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  f          out  WIDTH  result
//  n, z       out  1      f[WIDTH-1]; f==0
//  cout, ovf  out  1      carry out; signed overflow
//  err        out  1      illegal aop
// BEHAVIOUR
//  Reset: state=IDLE; f, n, z, cout, ovf, err, out_valid = 0; in_ready = 1.
//  Accept: in_valid & in_ready latches a, b, cin and aop at the clock edge.
//  States:
//  - IDLE -> EXEC for MUL, and for shifts with nonzero amount.
//  - IDLE -> DONE for all other ops.
//  - EXEC counts down and goes to DONE when the count reaches 0.
//  - DONE -> IDLE on out_ready (out_valid & out_ready). in_ready = 0 in DONE; no bypass.
//  Opcodes 0-7 (latency 1: out_valid high on the cycle after the accept edge):
//  - 0 ADD:  a + b + cin.
//  - 1 SUB:  a + ((~b+1) mod 2^W) + cin.
//  - 2 RSUB: ((~a+1) mod 2^W) + b + cin.
//  - 3 OR:   a|b.  4 AND: a&b.  5 ANDN: ~a&b.  6 XOR: a^b.  7 XNOR: a~^b.
//  - Add-type ops (0-2): cout = carry out of MSB; ovf = carry into MSB ^ carry out of MSB.
//    Both refer to the addition as written above.
//  - Logic ops (3-7): cout = ovf = 0.
//  Opcode 8, MUL (unsigned shift-add, one partial product per cycle):
//  - EXEC for WIDTH cycles; out_valid rises WIDTH+1 cycles after accept.
//  - f = low WIDTH bits of a*b; cout = ovf = |(high WIDTH bits).
//  Opcodes 9-11, shifts; amount s = b[SHW-1:0], one bit position per EXEC cycle:
//  - 9 SHL, 10 SHR (logical), 11 ASR (arithmetic).
//  - out_valid rises s+1 cycles after accept; s = 0 gives latency 1 and f = a.
//  - cout = last bit shifted out (0 when s = 0); ovf = 0.
//  Opcodes 12-15: illegal. Latency 1; f = 0, z = 1, n = cout = ovf = 0, err = 1.
//  Flags:
//  - n, z always derived from final f.
//  - err = 0 for legal ops.
//  - All outputs update only on the EXEC/IDLE->DONE edge and stay stable while out_valid.
//  Flush:
//  - In EXEC: abort, next state IDLE; outputs keep their previous values.
//  - In DONE: out_valid drops and state -> IDLE.
//  - In IDLE: ignored. Flush has priority over accept on the same cycle (no accept).
//  Async reset mid-operation: immediate return to reset values; partial state is discarded.
// TESTING (WIDTH=8)
//  1. ADD a=0x7F b=0x01 cin=0 -> next cycle out_valid=1; f=0x80 n=1 z=0 cout=0 ovf=1.
//  2. SUB a=0x05 b=0x05 cin=0 -> f=0x00 z=1 cout=1 ovf=0.
//     Hold out_ready=0 3 cycles -> out_valid and f stable, in_ready=0.
//  3. MUL a=0x10 b=0x10 -> out_valid exactly 9 cycles after accept; f=0x00 z=1 cout=1 ovf=1.
//     MUL a=0x0F b=0x03 -> f=0x2D cout=0.
//  4. SHL a=0x81 b=1 -> f=0x02 cout=1 (latency 2).
//     ASR a=0x80 b=3 -> f=0xF0 n=1 cout=0 (latency 4).
//     SHR a=0x81 b=0 -> f=0x81 cout=0 (latency 1).
//  5. MUL accepted, flush at EXEC cycle 4 -> no out_valid; in_ready=1 next cycle; new ADD completes normally.
//  6. aop=0xC -> err=1 f=0 z=1.
//     Assert rst_n=0 during MUL EXEC -> all outputs 0 asynchronously; in_ready=1.

Source files
------------

// File: rtl/ap_function_seq.sv
// Multicycle arithmetic function unit with valid/ready handshakes on both sides.
// Single-cycle ALU ops, an iterative shift-add multiply, and one-bit-per-cycle shifts.
module ap_function_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       aop,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             n,
  output logic             z,
  output logic             cout,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_RSUB = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_ANDN = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_ASR  = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   sh;
  logic [CW-1:0]      cnt;

  logic [SHW-1:0] samt;
  logic           is_shift;
  logic           multi;
  logic           accept;
  logic           last;

  assign samt     = b[SHW-1:0];
  assign is_shift = (aop == OP_SHL) || (aop == OP_SHR) || (aop == OP_ASR);
  assign multi    = (aop == OP_MUL) || (is_shift && (samt != '0));
  assign accept   = in_valid && (state == S_IDLE) && !flush;
  assign last     = (cnt == CW'(1));

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Single-cycle result computed straight from the operands being accepted.
  logic [WIDTH-1:0] add_x, add_y;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] add_low;
  logic [WIDTH-1:0] sc_f;
  logic             sc_cout, sc_ovf, sc_err;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sum = '0;
    add_low = '0;
    sc_f    = '0;
    sc_cout = 1'b0;
    sc_ovf  = 1'b0;
    sc_err  = 1'b0;
    case (aop)
      OP_ADD, OP_SUB, OP_RSUB: begin
        add_x   = (aop == OP_RSUB) ? -a : a;
        add_y   = (aop == OP_SUB)  ? -b : b;
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, cin};
        add_low = {1'b0, add_x[WIDTH-2:0]} + {1'b0, add_y[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin};
        sc_f    = add_sum[WIDTH-1:0];
        sc_cout = add_sum[WIDTH];
        sc_ovf  = add_low[WIDTH-1] ^ add_sum[WIDTH];
      end
      OP_OR:   sc_f = a | b;
      OP_AND:  sc_f = a & b;
      OP_ANDN: sc_f = ~a & b;
      OP_XOR:  sc_f = a ^ b;
      OP_XNOR: sc_f = a ~^ b;
      OP_MUL, OP_SHL, OP_SHR, OP_ASR: sc_f = a;  // only reached for zero-amount shifts
      default: sc_err = 1'b1;
    endcase
  end

  // One iteration step: right-shifting product register, one-bit shifter.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   sh_nxt;
  logic               sh_out;

  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
    prod_nxt = {mul_sum, prod[WIDTH-1:1]};
    sh_nxt   = sh;
    sh_out   = 1'b0;
    case (op_r)
      OP_SHL: begin sh_nxt = {sh[WIDTH-2:0], 1'b0};        sh_out = sh[WIDTH-1]; end
      OP_SHR: begin sh_nxt = {1'b0, sh[WIDTH-1:1]};        sh_out = sh[0];       end
      OP_ASR: begin sh_nxt = {sh[WIDTH-1], sh[WIDTH-1:1]}; sh_out = sh[0];       end
      default: ;
    endcase
  end

  logic [WIDTH-1:0] res_f;
  logic             res_cout, res_ovf, res_err;
  logic             load_out;

  always_comb begin
    res_f    = sc_f;
    res_cout = sc_cout;
    res_ovf  = sc_ovf;
    res_err  = sc_err;
    if (state == S_EXEC) begin
      res_err = 1'b0;
      if (op_r == OP_MUL) begin
        res_f    = prod_nxt[WIDTH-1:0];
        res_cout = |prod_nxt[2*WIDTH-1:WIDTH];
        res_ovf  = res_cout;
      end else begin
        res_f    = sh_nxt;
        res_cout = sh_out;
        res_ovf  = 1'b0;
      end
    end
  end

  assign load_out = (accept && !multi) || ((state == S_EXEC) && !flush && last);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = multi ? S_EXEC : S_DONE;
      S_EXEC: if (flush) state_nxt = S_IDLE;
              else if (last) state_nxt = S_DONE;
      S_DONE: if (flush || out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= '0;
      a_r  <= '0;
      prod <= '0;
      sh   <= '0;
      cnt  <= '0;
      f    <= '0;
      n    <= 1'b0;
      z    <= 1'b0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (accept) begin
        op_r <= aop;
        a_r  <= a;
        prod <= {{WIDTH{1'b0}}, b};
        sh   <= a;
        cnt  <= (aop == OP_MUL) ? CW'(WIDTH) : CW'(samt);
      end else if ((state == S_EXEC) && !flush) begin
        prod <= prod_nxt;
        sh   <= sh_nxt;
        cnt  <= cnt - CW'(1);
      end
      if (load_out) begin
        f    <= res_f;
        n    <= res_f[WIDTH-1];
        z    <= (res_f == '0);
        cout <= res_cout;
        ovf  <= res_ovf;
        err  <= res_err;
      end
    end
  end

endmodule

// File: tb/tb_ap_function_seq.sv
// Directed self-checking bench for ap_function_seq at WIDTH=8.
// Each scenario task drives one feature and compares against hand-computed values.
module tb_ap_function_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic [3:0] aop = '0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] f;
  logic       n, z, cout, ovf, err;

  int tests = 0;
  int fails = 0;

  ap_function_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .aop(aop), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .n(n), .z(z), .cout(cout), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // Present one operation for exactly one accept edge; returns #1 after that edge.
  task automatic start_op(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                          input logic c);
    aop = op; a = aa; b = bb; cin = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counted in edges from the accept edge (1 = valid right after accept).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL timeout: out_valid=%0b required 1 within 40 cycles", out_valid);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({out_valid, in_ready, f, n, z, cout, ovf, err} !== {1'b0, 1'b1, 8'h00, 5'b00000}) begin
      fails++;
      $display("FAIL reset: got ov=%0b ir=%0b f=%h nzco=%b%b%b%b err=%0b, required ov=0 ir=1 f=00 flags=0",
               out_valid, in_ready, f, n, z, cout, ovf, err);
    end
  endtask

  task automatic test_add();
    int lat;
    start_op(4'd0, 8'h7F, 8'h01, 1'b0);
    wait_done(lat);
    tests++;
    if (lat !== 1 || {f, n, z, cout, ovf, err} !== {8'h80, 5'b10010}) begin
      fails++;
      $display("FAIL add: lat=%0d f=%h n=%0b z=%0b c=%0b v=%0b e=%0b, required lat=1 f=80 n=1 z=0 c=0 v=1 e=0",
               lat, f, n, z, cout, ovf, err);
    end
    release_result();
    start_op(4'd2, 8'h01, 8'h00, 1'b0);
    wait_done(lat);
    tests++;
    if (lat !== 1 || {f, n, z, cout, ovf, err} !== {8'hFF, 5'b10000}) begin
      fails++;
      $display("FAIL rsub: lat=%0d f=%h n=%0b z=%0b c=%0b v=%0b, required lat=1 f=ff n=1 z=0 c=0 v=0",
               lat, f, n, z, cout, ovf);
    end
    release_result();
  endtask

  task automatic test_sub_hold();
    int lat;
    start_op(4'd1, 8'h05, 8'h05, 1'b0);
    wait_done(lat);
    tests++;
    if (lat !== 1 || {f, n, z, cout, ovf, err} !== {8'h00, 5'b01100}) begin
      fails++;
      $display("FAIL sub: lat=%0d f=%h n=%0b z=%0b c=%0b v=%0b, required lat=1 f=00 n=0 z=1 c=1 v=0",
               lat, f, n, z, cout, ovf);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({out_valid, in_ready, f, z} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
        fails++;
        $display("FAIL sub_hold[%0d]: ov=%0b ir=%0b f=%h z=%0b, required ov=1 ir=0 f=00 z=1",
                 i, out_valid, in_ready, f, z);
      end
    end
    release_result();
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL sub_release: ov=%0b ir=%0b, required ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_logic();
    logic [3:0] ops [5] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [7:0] exp [5] = '{8'hFC, 8'h30, 8'h0C, 8'hCC, 8'h33};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(ops[i], 8'hF0, 8'h3C, 1'b1);
      wait_done(lat);
      tests++;
      if (lat !== 1 || f !== exp[i] || n !== exp[i][7] || {z, cout, ovf, err} !== 4'b0000) begin
        fails++;
        $display("FAIL logic op%0d: lat=%0d f=%h n=%0b z=%0b c=%0b v=%0b e=%0b, required lat=1 f=%h n=%0b z=0 c=0 v=0 e=0",
                 ops[i], lat, f, n, z, cout, ovf, err, exp[i], exp[i][7]);
      end
      release_result();
    end
  endtask

  task automatic test_mul();
    int lat;
    start_op(4'd8, 8'h10, 8'h10, 1'b0);
    wait_done(lat);
    tests++;
    if (lat !== 9 || {f, n, z, cout, ovf, err} !== {8'h00, 5'b01110}) begin
      fails++;
      $display("FAIL mul_10x10: lat=%0d f=%h z=%0b c=%0b v=%0b, required lat=9 f=00 z=1 c=1 v=1",
               lat, f, z, cout, ovf);
    end
    release_result();
    start_op(4'd8, 8'h0F, 8'h03, 1'b0);
    wait_done(lat);
    tests++;
    if (lat !== 9 || {f, n, z, cout, ovf, err} !== {8'h2D, 5'b00000}) begin
      fails++;
      $display("FAIL mul_0fx03: lat=%0d f=%h c=%0b v=%0b, required lat=9 f=2d c=0 v=0",
               lat, f, cout, ovf);
    end
    release_result();
    start_op(4'd8, 8'hFF, 8'hFF, 1'b0);
    wait_done(lat);
    tests++;
    if (lat !== 9 || {f, n, z, cout, ovf, err} !== {8'h01, 5'b00110}) begin
      fails++;
      $display("FAIL mul_ffxff: lat=%0d f=%h c=%0b v=%0b, required lat=9 f=01 c=1 v=1",
               lat, f, cout, ovf);
    end
    release_result();
  endtask

  task automatic test_shift();
    int lat;
    start_op(4'd9, 8'h81, 8'h01, 1'b0);
    wait_done(lat);
    tests++;
    if (lat !== 2 || {f, n, z, cout, ovf, err} !== {8'h02, 5'b00100}) begin
      fails++;
      $display("FAIL shl: lat=%0d f=%h c=%0b v=%0b, required lat=2 f=02 c=1 v=0", lat, f, cout, ovf);
    end
    release_result();
    start_op(4'd11, 8'h80, 8'h03, 1'b0);
    wait_done(lat);
    tests++;
    if (lat !== 4 || {f, n, z, cout, ovf, err} !== {8'hF0, 5'b10000}) begin
      fails++;
      $display("FAIL asr: lat=%0d f=%h n=%0b c=%0b, required lat=4 f=f0 n=1 c=0", lat, f, n, cout);
    end
    release_result();
    start_op(4'd10, 8'hB4, 8'h03, 1'b0);
    wait_done(lat);
    tests++;
    if (lat !== 4 || {f, n, z, cout, ovf, err} !== {8'h16, 5'b00100}) begin
      fails++;
      $display("FAIL shr3: lat=%0d f=%h n=%0b c=%0b, required lat=4 f=16 n=0 c=1", lat, f, n, cout);
    end
    release_result();
    start_op(4'd10, 8'h81, 8'h00, 1'b0);
    wait_done(lat);
    tests++;
    if (lat !== 1 || {f, n, z, cout, ovf, err} !== {8'h81, 5'b10000}) begin
      fails++;
      $display("FAIL shr0: lat=%0d f=%h c=%0b, required lat=1 f=81 c=0", lat, f, cout);
    end
    release_result();
  endtask

  task automatic test_flush();
    int lat;
    bit seen;
    start_op(4'd8, 8'h0F, 8'h03, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++;
    if ({out_valid, in_ready, f, cout} !== {1'b0, 1'b1, 8'h81, 1'b0}) begin
      fails++;
      $display("FAIL flush_exec: ov=%0b ir=%0b f=%h c=%0b, required ov=0 ir=1 f=81 c=0",
               out_valid, in_ready, f, cout);
    end
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL flush_quiet: out_valid seen=%0b, required 0", seen);
    end
    start_op(4'd0, 8'h12, 8'h34, 1'b1);
    wait_done(lat);
    tests++;
    if (lat !== 1 || {f, n, z, cout, ovf, err} !== {8'h47, 5'b00000}) begin
      fails++;
      $display("FAIL add_after_flush: lat=%0d f=%h c=%0b v=%0b, required lat=1 f=47 c=0 v=0",
               lat, f, cout, ovf);
    end
    release_result();
    start_op(4'd0, 8'hFF, 8'h01, 1'b0);
    wait_done(lat);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++;
    if ({out_valid, in_ready, f, z, cout, ovf} !== {1'b0, 1'b1, 8'h00, 3'b110}) begin
      fails++;
      $display("FAIL flush_done: ov=%0b ir=%0b f=%h z=%0b c=%0b v=%0b, required ov=0 ir=1 f=00 z=1 c=1 v=0",
               out_valid, in_ready, f, z, cout, ovf);
    end
    flush = 1'b1;
    start_op(4'd0, 8'h01, 8'h01, 1'b0);
    flush = 1'b0;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL flush_blocks_accept: ov=%0b ir=%0b, required ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_illegal();
    int lat;
    start_op(4'hC, 8'h5A, 8'hA5, 1'b1);
    wait_done(lat);
    tests++;
    if (lat !== 1 || {f, n, z, cout, ovf, err} !== {8'h00, 5'b01001}) begin
      fails++;
      $display("FAIL illegal: lat=%0d f=%h n=%0b z=%0b c=%0b v=%0b e=%0b, required lat=1 f=00 n=0 z=1 c=0 v=0 e=1",
               lat, f, n, z, cout, ovf, err);
    end
    release_result();
  endtask

  task automatic test_async_reset();
    int lat;
    start_op(4'd8, 8'hFF, 8'hFF, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, in_ready, f, n, z, cout, ovf, err} !== {1'b0, 1'b1, 8'h00, 5'b00000}) begin
      fails++;
      $display("FAIL async_reset: ov=%0b ir=%0b f=%h nzcve=%b%b%b%b%b, required ov=0 ir=1 f=00 flags=0",
               out_valid, in_ready, f, n, z, cout, ovf, err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(4'd6, 8'h0F, 8'hFF, 1'b0);
    wait_done(lat);
    tests++;
    if (lat !== 1 || {f, n, z, err} !== {8'hF0, 3'b100}) begin
      fails++;
      $display("FAIL after_reset: lat=%0d f=%h n=%0b e=%0b, required lat=1 f=f0 n=1 e=0", lat, f, n, err);
    end
    release_result();
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_sub_hold();
    test_logic();
    test_mul();
    test_shift();
    test_flush();
    test_illegal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
